// File: rtl/audio_i2s_serializer.sv
// audio_i2s_serializer
//   I2S master for a stereo codec, 64 BCLK per frame (32 slots per channel).
//   Playback pairs are double-buffered (one pending pair plus the frame in flight).
//   Capture is optional and is built only when AUDIO_I2S_ADC_CAPTURE_EN is defined.
//   Without that macro, adcdat is ignored and the adc_* outputs are tied low.
//
// Parameters
//   BCLK_DIV  clk cycles per BCLK period (even, >= 4)
//   SAMPLE_W  bits per channel sample (2..31)
//
// Ports
//   clk            audio master clock
//   rst            asynchronous active-high reset
//   pll_locked     PLL lock, asynchronous to clk
//   dac_left/right playback sample pair
//   dac_valid      playback pair offered
//   dac_ready      pending-pair buffer is empty (only asserted while running)
//   dac_underflow  1-clk pulse: the frame just started is sent as zeros
//   bclk/lrck      serial bit clock and word select
//   dacdat         serial playback data
//   adcdat         serial capture data from the codec
//   adc_left/right last captured pair
//   adc_valid      1-clk strobe, new captured pair
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | PLL not locked (synchronized); bus quiet; all outputs at reset values
// RUN   | divider and slot counters running; frames are streamed
module audio_i2s_serializer #(
  parameter int BCLK_DIV = 6,
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pll_locked,
  input  logic [SAMPLE_W-1:0] dac_left,
  input  logic [SAMPLE_W-1:0] dac_right,
  input  logic                dac_valid,
  output logic                dac_ready,
  output logic                dac_underflow,
  output logic                bclk,
  output logic                lrck,
  output logic                dacdat,
  input  logic                adcdat,
  output logic [SAMPLE_W-1:0] adc_left,
  output logic [SAMPLE_W-1:0] adc_right,
  output logic                adc_valid
);

  localparam int HALF  = BCLK_DIV / 2;
  localparam int DIV_W = $clog2(BCLK_DIV);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_n;

  logic sync1, locked_s;

  logic [DIV_W-1:0] div, div_nxt;
  logic [5:0]       slot, slot_nxt;
  logic             div_last;
  logic             enter, running;
  logic             fall_n, frame_n;
  logic             left_n, right_n;

  logic [SAMPLE_W-1:0] buf_l, buf_r;
  logic                buf_full;
  logic [SAMPLE_W-1:0] tx_l, tx_r;
  logic                wr;

  // Lock synchronizer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= pll_locked;
      locked_s <= sync1;
    end
  end

  // FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    enter   = 1'b0;
    running = 1'b0;
    case (state)
      IDLE: begin
        if (locked_s) begin
          state_n = RUN;
          enter   = 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) state_n = IDLE;
        else           running = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Counter next values. Entering RUN lands directly on slot 0 / count 0,
  // so the entry cycle is itself a frame start.
  assign div_last = (div == DIV_W'(BCLK_DIV - 1));

  always_comb begin
    div_nxt  = '0;
    slot_nxt = '0;
    if (running) begin
      if (div_last) begin
        div_nxt  = '0;
        slot_nxt = slot + 6'd1;
      end else begin
        div_nxt  = div + DIV_W'(1);
        slot_nxt = slot;
      end
    end
  end

  // Events that the next cycle will present on the bus
  assign fall_n  = enter || (running && div_last);
  assign frame_n = fall_n && (slot_nxt == 6'd0);
  assign left_n  = (slot_nxt >= 6'd1)  && (slot_nxt <= 6'(SAMPLE_W));
  assign right_n = (slot_nxt >= 6'd33) && (slot_nxt <= 6'(32 + SAMPLE_W));

  assign dac_ready = (state == RUN) && !buf_full;
  assign wr        = dac_valid && dac_ready;

  // Playback datapath. Leaving RUN (or staying idle) clears everything,
  // which drops any partial frame and the pending pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div           <= '0;
      slot          <= '0;
      bclk          <= 1'b0;
      lrck          <= 1'b0;
      dacdat        <= 1'b0;
      dac_underflow <= 1'b0;
      buf_l         <= '0;
      buf_r         <= '0;
      buf_full      <= 1'b0;
      tx_l          <= '0;
      tx_r          <= '0;
    end else if (state_n != RUN) begin
      div           <= '0;
      slot          <= '0;
      bclk          <= 1'b0;
      lrck          <= 1'b0;
      dacdat        <= 1'b0;
      dac_underflow <= 1'b0;
      buf_l         <= '0;
      buf_r         <= '0;
      buf_full      <= 1'b0;
      tx_l          <= '0;
      tx_r          <= '0;
    end else begin
      div           <= div_nxt;
      slot          <= slot_nxt;
      bclk          <= (div_nxt >= DIV_W'(HALF));
      dac_underflow <= 1'b0;
      if (frame_n) begin
        lrck   <= 1'b0;
        dacdat <= 1'b0;
        if (buf_full) begin
          tx_l     <= buf_l;
          tx_r     <= buf_r;
          buf_full <= 1'b0;
        end else begin
          // A write landing on this same edge is too late for this frame;
          // it stays buffered for the next one.
          tx_l          <= '0;
          tx_r          <= '0;
          dac_underflow <= 1'b1;
          if (wr) begin
            buf_l    <= dac_left;
            buf_r    <= dac_right;
            buf_full <= 1'b1;
          end
        end
      end else begin
        if (fall_n) begin
          lrck <= slot_nxt[5];
          if (left_n) begin
            dacdat <= tx_l[SAMPLE_W-1];
            tx_l   <= {tx_l[SAMPLE_W-2:0], 1'b0};
          end else if (right_n) begin
            dacdat <= tx_r[SAMPLE_W-1];
            tx_r   <= {tx_r[SAMPLE_W-2:0], 1'b0};
          end else begin
            dacdat <= 1'b0;
          end
        end
        if (wr) begin
          buf_l    <= dac_left;
          buf_r    <= dac_right;
          buf_full <= 1'b1;
        end
      end
    end
  end

`ifdef AUDIO_I2S_ADC_CAPTURE_EN
  logic [SAMPLE_W-1:0] rx_l, rx_r;
  logic                rx_armed;
  logic                rise_s;
  logic                cap_left, cap_right;

  // Sample on the edge that raises bclk, using the slot currently on the bus
  assign rise_s    = running && (div == DIV_W'(HALF - 1));
  assign cap_left  = (slot >= 6'd1)  && (slot <= 6'(SAMPLE_W));
  assign cap_right = (slot >= 6'd33) && (slot <= 6'(32 + SAMPLE_W));

  // rx_armed keeps the entry frame (which has no complete capture) from
  // producing an adc_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_l      <= '0;
      rx_r      <= '0;
      rx_armed  <= 1'b0;
      adc_left  <= '0;
      adc_right <= '0;
      adc_valid <= 1'b0;
    end else if (state_n != RUN) begin
      rx_l      <= '0;
      rx_r      <= '0;
      rx_armed  <= 1'b0;
      adc_left  <= '0;
      adc_right <= '0;
      adc_valid <= 1'b0;
    end else begin
      adc_valid <= 1'b0;
      if (frame_n) begin
        if (rx_armed) begin
          adc_left  <= rx_l;
          adc_right <= rx_r;
          adc_valid <= 1'b1;
        end
        rx_armed <= 1'b1;
        rx_l     <= '0;
        rx_r     <= '0;
      end else if (rise_s) begin
        if (cap_left)       rx_l <= {rx_l[SAMPLE_W-2:0], adcdat};
        else if (cap_right) rx_r <= {rx_r[SAMPLE_W-2:0], adcdat};
      end
    end
  end
`else
  logic unused_adcdat;
  assign unused_adcdat = adcdat;
  assign adc_left      = '0;
  assign adc_right     = '0;
  assign adc_valid     = 1'b0;
`endif

endmodule

// File: tb/tb_audio_i2s_serializer.sv
// Directed bench for audio_i2s_serializer (default parameters).
// A small codec model drives adcdat from the observed bclk/lrck bus.
module tb_audio_i2s_serializer;

`ifdef AUDIO_I2S_ADC_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        pll_locked;
  logic [15:0] dac_left, dac_right;
  logic        dac_valid;
  logic        dac_ready, dac_underflow;
  logic        bclk, lrck, dacdat;
  logic        adcdat;
  logic [15:0] adc_left, adc_right;
  logic        adc_valid;

  int checks = 0;
  int errors = 0;

  audio_i2s_serializer #(.BCLK_DIV(6), .SAMPLE_W(16)) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .dac_left(dac_left), .dac_right(dac_right), .dac_valid(dac_valid),
    .dac_ready(dac_ready), .dac_underflow(dac_underflow),
    .bclk(bclk), .lrck(lrck), .dacdat(dacdat), .adcdat(adcdat),
    .adc_left(adc_left), .adc_right(adc_right), .adc_valid(adc_valid)
  );

  always #5 clk = ~clk;

  // Codec model: tracks the slot from bclk falls and lrck changes
  logic        codec_rst = 1'b1;
  logic [15:0] codec_l = 16'h1234;
  logic [15:0] codec_r = 16'hFEDC;
  logic        prev_bclk = 1'b0, prev_lrck = 1'b0;
  int          cslot = 0;

  initial adcdat = 1'b0;

  always @(negedge clk) begin
    if (codec_rst) cslot = 0;
    else if (prev_bclk && !bclk) begin
      if (lrck != prev_lrck) cslot = lrck ? 32 : 0;
      else                   cslot = cslot + 1;
    end
    if (cslot >= 1 && cslot <= 16)       adcdat = codec_l[16 - cslot];
    else if (cslot >= 33 && cslot <= 48) adcdat = codec_r[48 - cslot];
    else                                 adcdat = 1'b0;
    prev_bclk = bclk;
    prev_lrck = lrck;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits for the next frame start (lrck 1->0), optionally writes a pair in
  // that cycle, then records dacdat per slot and counts pulses over 384 clks.
  task automatic capture_frame(input logic do_wr, input logic [15:0] wl, input logic [15:0] wrr,
                               output logic [63:0] bits, output int uf_cnt, output int av_cnt,
                               output logic rdy0, output logic uf0,
                               output logic [15:0] al, output logic [15:0] ar);
    logic found, last_l;
    found  = 1'b0;
    last_l = lrck;
    for (int i = 0; i < 800 && !found; i++) begin
      @(negedge clk);
      if (last_l && !lrck) found = 1'b1;
      last_l = lrck;
    end
    check("frame_start_seen", {63'd0, found}, 64'd1);
    rdy0 = dac_ready;
    uf0  = dac_underflow;
    al   = adc_left;
    ar   = adc_right;
    if (do_wr) begin
      dac_left  = wl;
      dac_right = wrr;
      dac_valid = 1'b1;
    end
    bits   = '0;
    uf_cnt = 0;
    av_cnt = 0;
    for (int c = 0; c < 384; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) dac_valid = 1'b0;
      if (c % 6 == 0) bits[63 - c / 6] = dacdat;
      uf_cnt += int'(dac_underflow);
      av_cnt += int'(adc_valid);
    end
  endtask

  logic [63:0] bits;
  int          uf_cnt, av_cnt, n, rise_cyc, rise_at;
  logic        rdy0, uf0, rdy2, rdy3, uf3, pl, any_dat;
  logic [15:0] al, ar;
  logic [63:0] exp_play1, exp_play2;

  initial begin
    exp_play1 = {1'b0, 16'hA55A, 15'd0, 1'b0, 16'h8001, 15'd0};
    exp_play2 = {1'b0, 16'h3C5A, 15'd0, 1'b0, 16'h7E81, 15'd0};
    rst        = 1'b1;
    pll_locked = 1'b0;
    dac_left   = '0;
    dac_right  = '0;
    dac_valid  = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_bclk",  {63'd0, bclk}, 64'd0);
    check("rst_lrck",  {63'd0, lrck}, 64'd0);
    check("rst_dacdat", {63'd0, dacdat}, 64'd0);
    check("rst_ready", {63'd0, dac_ready}, 64'd0);
    check("rst_uf",    {63'd0, dac_underflow}, 64'd0);
    check("rst_adc",   {31'd0, adc_valid, adc_left, adc_right}, 64'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_ready", {63'd0, dac_ready}, 64'd0);

    // Lock: RUN on the 3rd edge, first bclk rise on the 6th
    pll_locked = 1'b1;
    codec_rst  = 1'b0;
    rise_cyc = 0; rdy2 = 1'b1; rdy3 = 1'b0; uf3 = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (cyc == 2) rdy2 = dac_ready;
      if (cyc == 3) begin rdy3 = dac_ready; uf3 = dac_underflow; end
      if (bclk && rise_cyc == 0) rise_cyc = cyc;
    end
    check("lock_ready_before_run", {63'd0, rdy2}, 64'd0);
    check("lock_ready_at_run", {63'd0, rdy3}, 64'd1);
    check("lock_entry_underflow", {63'd0, uf3}, 64'd1);
    check("lock_first_bclk_rise", 64'(rise_cyc), 64'd6);

    // bclk period
    pl = bclk;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!pl && bclk) break;
      pl = bclk;
    end
    n = 0; pl = bclk;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (!pl && bclk) break;
      pl = bclk;
    end
    check("bclk_period", 64'(n), 64'd6);

    // lrck period
    pl = lrck;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (!pl && lrck) break;
      pl = lrck;
    end
    n = 0; pl = lrck;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      n++;
      if (!pl && lrck) break;
      pl = lrck;
    end
    check("lrck_period", 64'(n), 64'd384);

    // Playback: write mid-frame, expect it in the next frame
    dac_left = 16'hA55A; dac_right = 16'h8001; dac_valid = 1'b1;
    @(negedge clk);
    dac_valid = 1'b0;
    check("play_ready_after_write", {63'd0, dac_ready}, 64'd0);
    capture_frame(1'b0, 16'h0, 16'h0, bits, uf_cnt, av_cnt, rdy0, uf0, al, ar);
    check("play_bits", bits, exp_play1);
    check("play_uf_count", 64'(uf_cnt), 64'd0);
    check("play_ready_at_start", {63'd0, rdy0}, 64'd1);
    check("cap_valid_count", 64'(av_cnt), CAP ? 64'd1 : 64'd0);
    check("cap_left", {48'd0, al}, CAP ? 64'h1234 : 64'd0);
    check("cap_right", {48'd0, ar}, CAP ? 64'hFEDC : 64'd0);

    // Underflow: no write
    capture_frame(1'b0, 16'h0, 16'h0, bits, uf_cnt, av_cnt, rdy0, uf0, al, ar);
    check("uf_bits", bits, 64'd0);
    check("uf_count", 64'(uf_cnt), 64'd1);
    check("uf_at_slot0", {63'd0, uf0}, 64'd1);

    // Write coinciding with frame start on an empty buffer
    capture_frame(1'b1, 16'h3C5A, 16'h7E81, bits, uf_cnt, av_cnt, rdy0, uf0, al, ar);
    check("sim_bits", bits, 64'd0);
    check("sim_uf_count", 64'(uf_cnt), 64'd1);
    check("sim_uf_at_slot0", {63'd0, uf0}, 64'd1);
    check("sim_ready_held", {63'd0, dac_ready}, 64'd0);
    capture_frame(1'b0, 16'h0, 16'h0, bits, uf_cnt, av_cnt, rdy0, uf0, al, ar);
    check("sim_next_bits", bits, exp_play2);
    check("sim_next_uf_count", 64'(uf_cnt), 64'd0);

    // Lock loss at slot 20 with a pair pending
    pl = lrck;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (pl && !lrck) break;
      pl = lrck;
    end
    repeat (60) @(negedge clk);
    dac_left = 16'hFFFF; dac_right = 16'hFFFF; dac_valid = 1'b1;
    @(negedge clk);
    dac_valid = 1'b0;
    repeat (59) @(negedge clk);
    pll_locked = 1'b0;
    codec_rst  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("loss_bclk", {63'd0, bclk}, 64'd0);
    check("loss_lrck", {63'd0, lrck}, 64'd0);
    check("loss_dacdat", {63'd0, dacdat}, 64'd0);
    check("loss_ready", {63'd0, dac_ready}, 64'd0);
    check("loss_uf", {63'd0, dac_underflow}, 64'd0);
    check("loss_adc", {31'd0, adc_valid, adc_left, adc_right}, 64'd0);
    repeat (4) @(negedge clk);

    // Relock: restart at slot 0 with the buffer empty
    pll_locked = 1'b1;
    codec_rst  = 1'b0;
    repeat (3) @(negedge clk);
    check("relock_ready", {63'd0, dac_ready}, 64'd1);
    check("relock_uf", {63'd0, dac_underflow}, 64'd1);
    uf_cnt = 0; av_cnt = 0; rise_at = -1; any_dat = 1'b0; pl = lrck;
    for (int c = 0; c < 384; c++) begin
      if (c > 0) @(negedge clk);
      if (lrck && !pl && rise_at < 0) rise_at = c;
      pl = lrck;
      uf_cnt += int'(dac_underflow);
      av_cnt += int'(adc_valid);
      any_dat |= dacdat;
    end
    check("relock_lrck_rise", 64'(rise_at), 64'd192);
    check("relock_uf_count", 64'(uf_cnt), 64'd1);
    check("relock_no_adc_valid", 64'(av_cnt), 64'd0);
    check("relock_zero_frame", {63'd0, any_dat}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_i2s_serializer.md
AUDIO_I2S_SERIALIZER -- requirements
Module: audio_i2s_serializer

Interface
REQ-001 SHALL have parameter BCLK_DIV, default 6; clk cycles per BCLK period (even, >=4); 18.432 MHz/6 = 3.072 MHz = 64 x 48 kHz.
REQ-002 SHALL have parameter SAMPLE_W, default 16; bits per channel sample (<=31).
REQ-003 SHALL have port clk, input, 1; audio master clock (18.432 MHz PLL output); also driven to codec MCLK externally.
REQ-004 SHALL have port rst, input, 1; asynchronous, active-high reset.
REQ-005 SHALL have port pll_locked, input, 1; PLL lock indication, asynchronous to clk.
REQ-006 SHALL have ports dac_left / dac_right, input, SAMPLE_W each; playback sample pair.
REQ-007 SHALL have ports dac_valid (input, 1) and dac_ready (output, 1); playback handshake.
REQ-008 SHALL have port dac_underflow, output, 1; one-clk pulse, frame sent with zeros.
REQ-009 SHALL have ports bclk, lrck, dacdat, each output, 1; codec serial bus.
REQ-010 SHALL have port adcdat, input, 1; codec capture data.
REQ-011 SHALL have ports adc_left / adc_right (output, SAMPLE_W each) and adc_valid (output, 1); captured pair plus one-clk strobe.
REQ-012 SHALL have one clock, clk; reset rst, asynchronous, active-high.

Function
REQ-013 SHALL pass pll_locked through a 2-flop synchronizer; the synchronized value is locked_s.
REQ-014 SHALL implement states IDLE and RUN: IDLE->RUN when locked_s=1; RUN->IDLE when locked_s=0, taking effect on the next clk with all outputs at reset values.
REQ-015 SHALL run a divider counter 0..BCLK_DIV-1 in RUN: bclk=0 for counts 0..BCLK_DIV/2-1, bclk=1 otherwise; count 0 is the BCLK falling edge.
REQ-016 SHALL run a slot counter 0..63, advancing on each falling edge and wrapping 63->0; slot 0 is frame start.
REQ-017 SHALL drive lrck=0 for slots 0..31 (left) and lrck=1 for slots 32..63 (right), changing on falling edges.
REQ-018 SHALL use I2S framing: left MSB in slot 1, right MSB in slot 33, SAMPLE_W bits MSB-first, dacdat=0 in unused slots.
REQ-019 SHALL update dacdat only on falling edges.
REQ-020 SHALL hold one sample pair in a buffer: dac_ready=1 iff buffer empty (and state RUN); transfer on dac_valid&dac_ready.
REQ-021 SHALL move the buffer into the shift register and empty it at frame start when full; when empty, SHALL send zeros and pulse dac_underflow.
REQ-022 SHALL, for a write in the frame-start cycle with an empty buffer, send zeros this frame and keep the written pair for the next frame.
REQ-023 SHALL sample adcdat on the clk where the divider reaches BCLK_DIV/2 (rising edge), in slots 1..SAMPLE_W and 33..32+SAMPLE_W.
REQ-024 SHALL, at the next frame start, update adc_left/adc_right and pulse adc_valid for 1 clk; the first frame after entering RUN produces no adc_valid.

Reset
REQ-025 SHALL on rst=1 asynchronously set: state IDLE, synchronizer 0, counters 0, buffer empty, bclk=0, lrck=0, dacdat=0, dac_ready=0, dac_underflow=0, adc_left=0, adc_right=0, adc_valid=0.
REQ-026 SHALL discard a partially sent frame and the buffered pair on reset or on lock loss.

Configuration
REQ-027 SHALL include the capture path (REQ-023/024) when macro AUDIO_I2S_ADC_CAPTURE_EN is defined; otherwise adcdat SHALL be ignored and adc_left/adc_right/adc_valid tied to 0.

Verification
REQ-028 SHALL cover lock: pll_locked 0->1 -> first bclk rise no earlier than 3 clk later; bclk period 6 clk; lrck period 384 clk.
REQ-029 SHALL cover playback: write L=16'hA55A, R=16'h8001 before frame start -> dacdat slots 1..16 = A55A, slots 33..48 = 8001, dac_ready returns to 1 at frame start.
REQ-030 SHALL cover underflow: no write in a frame -> all-zero dacdat for that frame, dac_underflow single pulse at slot 0.
REQ-031 SHALL cover simultaneous events: write coinciding with frame start on an empty buffer -> zeros plus underflow this frame, written pair sent next frame.
REQ-032 SHALL cover capture (macro defined): codec model drives L=16'h1234, R=16'hFEDC -> adc_valid pulse at next frame start with those values; macro undefined -> outputs stay 0.
REQ-033 SHALL cover lock loss: pll_locked dropped mid-frame (slot 20) -> within 3 clk all outputs at reset values; relock -> restarts at slot 0 with buffer empty.
